// File: rtl/multiply_tokens_pkg.sv
// Shared constants, result type and a saturating-add helper for the token multiplier.
package multiply_tokens_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int MULT_W_DEF = 3;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_res_t;

  // pending + add - sub, clamped to 2**cnt_w-1; ovf marks that clamping happened.
  function automatic sat_res_t sat_add(input logic [31:0] pend,
                                       input logic [31:0] add,
                                       input logic        sub,
                                       input int          cnt_w);
    logic [33:0] n;
    logic [33:0] mx;
    sat_res_t    r;
    n  = {2'b00, pend} + {2'b00, add} - {33'd0, sub};
    mx = (34'd1 << cnt_w) - 34'd1;
    if (n > mx) begin
      r.ovf = 1'b1;
      r.val = mx[31:0];
    end else begin
      r.ovf = 1'b0;
      r.val = n[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/multiply_tokens_sat_updown_counter.sv
// Generic saturating counter: adds i_add, subtracts i_sub each cycle, clamps at
// 2**CNT_W-1 and pulses o_ovf on any cycle where the clamp discards tokens.
module sat_updown_counter
  import multiply_tokens_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ADD_W = MULT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADD_W-1:0] i_add,
  input  logic             i_sub,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  // One spare bit above CNT_W+ADD_W so the intermediate sum cannot wrap.
  localparam int W = CNT_W + ADD_W + 1;
  localparam logic [W-1:0] MAX = {{(ADD_W+1){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     w_next;
  logic             w_sat;

  // Next count at full width, then saturation detect.
  always_comb begin
    w_next = {{(ADD_W+1){1'b0}}, r_cnt}
           + {{(CNT_W+1){1'b0}}, i_add}
           - {{(W-1){1'b0}}, i_sub};
    w_sat  = (w_next > MAX);
  end

  // Counter register; clamps to all-ones when the sum does not fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (w_sat) r_cnt <= {CNT_W{1'b1}};
    else            r_cnt <= w_next[CNT_W-1:0];
  end

  assign o_cnt = r_cnt;
  assign o_ovf = w_sat;

endmodule

// File: rtl/multiply_tokens.sv
// Token-rate multiplier: each accepted input token owes `mult` output tokens,
// emitted one per cycle while the consumer is ready. Owed tokens live in a
// saturating counter; loss through saturation is latched in a sticky flag.
module multiply_tokens
  import multiply_tokens_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MULT_W = MULT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic [MULT_W-1:0] mult,
  input  logic              b_ready,
  input  logic              clr_ovf,
  output logic              b,
  output logic [CNT_W-1:0]  pending,
  output logic              overflow
);

  localparam int W = CNT_W + MULT_W + 1;

  logic [MULT_W-1:0] w_add;
  logic [W-1:0]      w_avail;
  logic              w_b;
  logic              w_sat;
  logic [CNT_W-1:0]  w_pending;
  logic              r_ovf;

  // Tokens available this cycle include the arriving ones, giving a
  // zero-latency bypass when the counter is empty.
  always_comb begin
    w_add   = a ? mult : '0;
    w_avail = {{(MULT_W+1){1'b0}}, w_pending} + {{(CNT_W+1){1'b0}}, w_add};
    w_b     = b_ready & (w_avail != '0);
  end

  sat_updown_counter #(
    .CNT_W (CNT_W),
    .ADD_W (MULT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_add (w_add),
    .i_sub (w_b),
    .o_cnt (w_pending),
    .o_ovf (w_sat)
  );

  // Sticky overflow: a saturation event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_sat)   r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign b        = w_b;
  assign pending  = w_pending;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_multiply_tokens.sv
// Directed bench for multiply_tokens: inputs change on the falling edge, outputs
// are sampled 1ns later, so `pending` shows the state from the previous rise.
module tb_multiply_tokens;
  import multiply_tokens_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic [2:0] mult = '0;
  logic       b_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       b;
  logic [3:0] pending;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  multiply_tokens #(.CNT_W(4), .MULT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .mult     (mult),
    .b_ready  (b_ready),
    .clr_ovf  (clr_ovf),
    .b        (b),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ia, input logic [2:0] im, input logic br, input logic cl);
    @(negedge clk);
    a = ia; mult = im; b_ready = br; clr_ovf = cl;
    #1;
  endtask

  initial begin
    logic [11:0] hist;
    int          cnt_a, cnt_b, bad;
    logic [31:0] m;
    sat_res_t    r;
    logic        ia, eb;

    // Reset state
    #2;
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_b", b, 0);
    @(negedge clk); rst_n = 1'b1;

    // mult=0 token yields nothing
    drive(1, 0, 1, 0);
    chk("mult0_b", b, 0);
    drive(0, 0, 1, 0);
    chk("mult0_pending", pending, 0);

    // Variable factor 3,0,5,0 then drain: 8 consecutive tokens
    hist = '0;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: drive(1, 3, 1, 0);
        1: drive(1, 0, 1, 0);
        2: drive(1, 5, 1, 0);
        3: drive(1, 0, 1, 0);
        default: drive(0, 0, 1, 0);
      endcase
      hist[i] = b;
    end
    chk("var_pattern", {20'd0, hist}, 32'h0FF);
    chk("var_pending", pending, 0);

    // Back-pressure: 3 x mult=4 with b_ready=0
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4, 0, 0);
      if (b !== 1'b0) bad++;
    end
    drive(0, 0, 0, 0);
    chk("bp_b_low", bad, 0);
    chk("bp_pending", pending, 12);
    cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0);
      cnt_b += int'(b);
    end
    chk("bp_drain_count", cnt_b, 12);
    chk("bp_drain_pending", pending, 0);

    // x2 compatibility with random arrivals, cycle-checked against sat_add
    cnt_a = 0; cnt_b = 0; bad = 0; m = 0;
    for (int i = 0; i < 300; i++) begin
      ia = (i < 100) && ($urandom_range(0, 99) < 30);
      drive(ia, 2, 1, 0);
      eb = (m + (ia ? 32'd2 : 32'd0)) != 0;
      if (b !== eb || pending !== m[3:0]) bad++;
      cnt_a += int'(ia);
      cnt_b += int'(b);
      r = sat_add(m, ia ? 32'd2 : 32'd0, eb, 4);
      m = r.val;
    end
    chk("x2_cycle_errs", bad, 0);
    chk("x2_count", cnt_b, 2 * cnt_a);
    chk("x2_overflow", overflow, 0);
    chk("x2_pending", pending, 0);

    // Saturation: continuous mult=7
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1, 7, 1, 0);
      if (b !== 1'b1) bad++;
    end
    chk("sat_b_every_cycle", bad, 0);
    chk("sat_pending", pending, 15);
    chk("sat_overflow", overflow, 1);
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0);
      cnt_b += int'(b);
    end
    chk("sat_drain_count", cnt_b, 15);
    chk("sat_ovf_sticky", overflow, 1);
    chk("sat_drain_pending", pending, 0);

    // Clear while idle
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    chk("clr_idle", overflow, 0);

    // Saturate, then clear on a cycle that lands exactly at 15 (no event)
    drive(1, 7, 1, 0);   // -> 6
    drive(1, 7, 1, 0);   // -> 12
    drive(1, 7, 1, 0);   // 18 -> saturate
    drive(1, 1, 1, 1);   // 15+1-1 = 15, clear applies
    chk("edge_pending", pending, 15);
    drive(0, 0, 1, 0);
    chk("clr_at_max", overflow, 0);
    chk("clr_at_max_pending", pending, 15);

    // Set wins over clear in the same cycle
    drive(1, 7, 1, 1);   // 14+7-1 = 20 -> saturate with clr
    drive(0, 0, 1, 0);
    chk("set_wins", overflow, 1);

    // Drain, then build pending=9 under back-pressure and reset mid-cycle
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
    drive(1, 7, 0, 0);
    drive(1, 2, 0, 0);
    drive(0, 0, 1, 0);
    chk("pre_rst_pending", pending, 9);
    chk("pre_rst_b", b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_b", b, 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      if (b !== 1'b0) bad++;
    end
    chk("post_rst_no_b", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
